// File: rtl/muxn_arb_reg_if.sv
// Channel bundle for muxn_arb_reg: N producer channels in, one registered consumer port out.
// The err signal exists only when MUXN_ERR_EN is defined.
interface muxn_arb_reg_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    grant;
`ifdef MUXN_ERR_EN
  logic               err;

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, grant, err
  );
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, grant, err
  );
`else
  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, grant
  );
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, grant
  );
`endif
endinterface

// File: rtl/muxn_arb_reg.sv
// N-input selector (fixed select or round-robin) feeding a one-entry registered output stage.
// Optional sticky out-of-range select flag enabled by defining MUXN_ERR_EN.
module muxn_arb_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic          clk,
  input  logic          rst,
  muxn_arb_reg_if.slave bus
);
  localparam int SELW = $clog2(N);

  logic [SELW-1:0]  r_rr_ptr;
  logic [SELW-1:0]  r_grant;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;

  logic [SELW-1:0]  w_winner;
  logic [SELW-1:0]  w_scan_idx;
  logic [SELW:0]    w_scan_sum;
  logic [WIDTH-1:0] w_win_data;
  logic [N-1:0]     w_in_ready;
  logic             w_load_en;
  logic             w_sel_ok;
  logic             w_rr_hit;
  logic             w_hit;
  logic             w_xfer;

  assign w_load_en = !r_out_valid || bus.out_ready;
  assign w_sel_ok  = ({1'b0, bus.sel} < (SELW+1)'(N));

  // Round-robin scan starting at r_rr_ptr; wrap by subtraction so N need not be a power of two.
  always_comb begin
    w_rr_hit   = 1'b0;
    w_scan_idx = '0;
    w_scan_sum = '0;
    for (int k = 0; k < N; k++) begin
      w_scan_sum = {1'b0, r_rr_ptr} + (SELW+1)'(k);
      if (w_scan_sum >= (SELW+1)'(N)) begin
        w_scan_sum = w_scan_sum - (SELW+1)'(N);
      end
      if (!w_rr_hit && bus.in_valid[w_scan_sum[SELW-1:0]]) begin
        w_rr_hit   = 1'b1;
        w_scan_idx = w_scan_sum[SELW-1:0];
      end
    end
  end

  assign w_winner = bus.mode ? w_scan_idx : bus.sel;
  assign w_hit    = bus.mode ? w_rr_hit : (w_sel_ok && bus.in_valid[bus.sel]);
  assign w_xfer   = w_load_en && w_hit;

  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_winner == SELW'(i)) begin
        w_win_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // In fixed mode ready ignores the channel's own valid, so a producer may wait on ready.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign w_in_ready[gi] = w_load_en && (w_winner == SELW'(gi)) &&
                              (bus.mode ? w_rr_hit : w_sel_ok);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load_en) begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_win_data;
        r_grant     <= w_winner;
        if (bus.mode) begin
          r_rr_ptr <= (w_winner == SELW'(N-1)) ? '0 : w_winner + SELW'(1);
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef MUXN_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (!bus.mode && !w_sel_ok) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.grant     = r_grant;
endmodule

// File: tb/tb_muxn_arb_reg.sv
// Self-checking bench for muxn_arb_reg: directed scenarios plus random traffic against a queue-free model.
// Exercises an N=4 instance and an N=3 instance (out-of-range select, MUXN_ERR_EN flag).
module tb_muxn_arb_reg;
  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  muxn_arb_reg_if #(.WIDTH(32), .N(4)) bus4 ();
  muxn_arb_reg_if #(.WIDTH(32), .N(3)) bus3 ();

  muxn_arb_reg #(.WIDTH(32), .N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  muxn_arb_reg #(.WIDTH(32), .N(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state for the N=4 instance
  bit          m_valid;
  logic [31:0] m_data;
  int          m_grant;
  int          m_ptr;
  bit          m_mode;
  int          m_sel;
  logic [3:0]  m_v;
  bit          m_ordy;
  logic [31:0] din [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner();
    if (!m_mode) return (m_sel < 4 && m_v[m_sel]) ? m_sel : -1;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (m_v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int w;
    if (m_valid && !m_ordy) return 4'b0000;
    if (!m_mode) return (m_sel < 4) ? 4'(1 << m_sel) : 4'b0000;
    w = model_winner();
    return (w >= 0) ? 4'(1 << w) : 4'b0000;
  endfunction

  task automatic apply();
    bus4.mode      = m_mode;
    bus4.sel       = 2'(m_sel);
    bus4.in_valid  = m_v;
    bus4.out_ready = m_ordy;
    for (int c = 0; c < 4; c++) bus4.in_data[c*32 +: 32] = din[c];
  endtask

  task automatic drive(input bit mode, input int sel, input logic [3:0] v, input bit ordy);
    m_mode = mode;
    m_sel  = sel;
    m_v    = v;
    m_ordy = ordy;
    for (int c = 0; c < 4; c++) din[c] = $urandom;
    apply();
  endtask

  // One clock: check ready before the edge, advance the model, check registered outputs after it.
  task automatic step(input string tag);
    int w;
    bit le;
    #1;
    chk({tag, "/in_ready"}, 64'(bus4.in_ready), 64'(model_ready()));
    w  = model_winner();
    le = !m_valid || m_ordy;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = 0; m_grant = 0; m_ptr = 0;
    end else if (le) begin
      if (w >= 0) begin
        m_valid = 1; m_data = din[w]; m_grant = w;
        if (m_mode) m_ptr = (w + 1) % 4;
      end else begin
        m_valid = 0;
      end
    end
    @(negedge clk);
    chk({tag, "/out_valid"}, 64'(bus4.out_valid), 64'(m_valid));
    chk({tag, "/grant"},     64'(bus4.grant),     64'(m_grant));
    chk({tag, "/out_data"},  64'(bus4.out_data),  64'(m_data));
  endtask

  initial begin
    logic [31:0] d3;
    rst = 1'b1;
    drive(1, 0, 4'b1111, 1);
    bus3.mode = 1'b1; bus3.sel = 2'd0; bus3.in_valid = 3'b000; bus3.out_ready = 1'b1;
    bus3.in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_valid = 0; m_data = 0; m_grant = 0; m_ptr = 0;

    // Reset held with every channel requesting
    step("rst_hold");
    chk("rst_hold/out_valid_const", 64'(bus4.out_valid), 64'd0);
    chk("rst_hold/grant_const", 64'(bus4.grant), 64'd0);
    rst = 1'b0;

    // Round-robin from reset: ch0, ch1, ch2, ch3, ch0
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 4'b1111, 1);
      step("rr_seq");
      chk("rr_seq/grant_const", 64'(bus4.grant), 64'(k % 4));
    end

    // Fixed select ch2, back-to-back loads
    for (int k = 0; k < 3; k++) begin
      drive(0, 2, 4'b1111, 1);
      #1 chk("sel2/in_ready_const", 64'(bus4.in_ready), 64'b0100);
      step("sel2");
    end

    // Stall with ch1 word held
    drive(0, 1, 4'b0010, 1);
    din[1] = 32'hA5A5A5A5;
    apply();
    step("stall_load");
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 4'b1111, 0);
      step("stall");
      chk("stall/grant_const", 64'(bus4.grant), 64'd1);
      chk("stall/data_const", 64'(bus4.out_data), 64'hA5A5A5A5);
    end
    drive(0, 3, 4'b1000, 1);
    step("stall_release");
    chk("stall_release/grant_const", 64'(bus4.grant), 64'd3);

    // Pointer at 3 with only ch0/ch1 requesting: ch0, ch1, ch0
    drive(1, 0, 4'b0100, 1);
    step("ptr3_setup");
    drive(1, 0, 4'b0011, 1); step("ptr3"); chk("ptr3/g0", 64'(bus4.grant), 64'd0);
    drive(1, 0, 4'b0011, 1); step("ptr3"); chk("ptr3/g1", 64'(bus4.grant), 64'd1);
    drive(1, 0, 4'b0011, 1); step("ptr3"); chk("ptr3/g2", 64'(bus4.grant), 64'd0);

    // Random traffic with occasional reset
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 3), 4'($urandom),
            ($urandom_range(0, 3) != 0));
      rst = ($urandom_range(0, 39) == 0);
      step("rand");
    end
    rst = 1'b0;

    // Reset while a word is stalled
    drive(0, 0, 4'b0001, 1); step("rst_stall_load");
    drive(0, 0, 4'b0001, 0); step("rst_stall_hold");
    rst = 1'b1;
    step("rst_stall");
    chk("rst_stall/out_valid_const", 64'(bus4.out_valid), 64'd0);
    chk("rst_stall/out_data_const", 64'(bus4.out_data), 64'd0);
    rst = 1'b0;

    // N=3 instance: out-of-range select
    rst = 1'b1;
    bus3.mode = 1'b0; bus3.sel = 2'd3; bus3.in_valid = 3'b111; bus3.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) bus3.in_data[c*32 +: 32] = $urandom;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("n3_sel3/in_ready", 64'(bus3.in_ready), 64'd0);
      @(posedge clk); @(negedge clk);
      chk("n3_sel3/out_valid", 64'(bus3.out_valid), 64'd0);
`ifdef MUXN_ERR_EN
      chk("n3_sel3/err", 64'(bus3.err), 64'd1);
`endif
    end
    bus3.sel = 2'd1;
    d3 = bus3.in_data[32 +: 32];
    #1 chk("n3_sel1/in_ready", 64'(bus3.in_ready), 64'b010);
    @(posedge clk); @(negedge clk);
    chk("n3_sel1/out_valid", 64'(bus3.out_valid), 64'd1);
    chk("n3_sel1/grant", 64'(bus3.grant), 64'd1);
    chk("n3_sel1/out_data", 64'(bus3.out_data), 64'(d3));
`ifdef MUXN_ERR_EN
    chk("n3_sel1/err_sticky", 64'(bus3.err), 64'd1);
`endif
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("n3_rst/out_valid", 64'(bus3.out_valid), 64'd0);
`ifdef MUXN_ERR_EN
    chk("n3_rst/err", 64'(bus3.err), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
